// File: rtl/vga_timing_pkg.sv
// Purpose: shared timing constants and types for the VGA raster generator (640x480@60).
// Latency: n/a (constants, types and a polarity helper only).
// Backpressure: n/a.
package vga_timing_pkg;

  // Default horizontal timing, in pixel clocks.
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  // Default vertical timing, in lines.
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_BOTTOM_DEF  = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_TOP_DEF     = 33;

  // Last coordinate on each axis: 799 and 524 for the defaults.
  localparam int H_MAX_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF - 1;
  localparam int V_MAX_DEF = V_DISPLAY_DEF + V_BOTTOM_DEF + V_SYNC_DEF + V_TOP_DEF - 1;

  // Classic VGA 640x480 uses negative-going sync pulses.
  localparam bit SYNC_ACTIVE_LOW_DEF = 1'b1;

  localparam int COORD_W   = 10;
  localparam int COORD_LIM = (1 << COORD_W) - 1;

  typedef logic [COORD_W-1:0] coord_t;

  // Map "inside the sync window" to the pin level for the chosen polarity.
  function automatic logic sync_level(input logic active, input bit active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: one raster axis: wrapping 0..MAX counter plus a registered sync pulse for that axis.
// Latency: sync is computed from the next count, so it changes on the same edge as cnt.
// Backpressure: none; advances whenever en is high.
// Ports:
//   clk, reset    pixel clock, async active-high reset
//   en            advance the count this cycle
//   cnt           current coordinate (registered)
//   wrap          combinational: en is high and cnt is at MAX (next edge returns to 0)
//   sync          registered sync level, already at output polarity
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int MAX             = H_MAX_DEF,
  parameter int SYNC_START      = H_DISPLAY_DEF + H_FRONT_DEF,
  parameter int SYNC_END        = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF - 1,
  parameter bit SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output logic               sync
);

  coord_t cnt_q, cnt_d;
  logic   sync_q, sync_d;
  logic   at_max;
  logic   in_window;

  always_comb begin
    at_max = (cnt_q == coord_t'(MAX));
    cnt_d  = cnt_q;
    if (en) begin
      cnt_d = at_max ? '0 : cnt_q + coord_t'(1);
    end
    // Window test on the next count keeps sync edge-aligned with cnt.
    in_window = (cnt_d >= coord_t'(SYNC_START)) && (cnt_d <= coord_t'(SYNC_END));
    sync_d    = sync_level(in_window, SYNC_ACTIVE_LOW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      sync_q <= sync_level(1'b0, SYNC_ACTIVE_LOW);
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = en && at_max;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: free-running VGA raster timing (hsync/vsync/display_on/hpos/vpos), 640x480@60 by default.
// Latency: hsync/vsync/strobes registered and aligned with hpos/vpos; display_on combinational from them.
// Backpressure: none; the raster free-runs from the pixel clock.
// Ports:
//   clk          25 MHz pixel clock
//   reset        async active-high reset (outputs return to reset values immediately)
//   hsync/vsync  registered sync outputs, polarity set by SYNC_ACTIVE_LOW
//   display_on   high while (hpos,vpos) is in the visible area
//   hpos/vpos    current beam column/line, 10 bits
//   line_start   (VGA_TIMING_STROBES_EN only) one cycle at hpos==0
//   frame_start  (VGA_TIMING_STROBES_EN only) one cycle at hpos==0 && vpos==0
// Build option: define VGA_TIMING_STROBES_EN to add line_start/frame_start.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int V_BOTTOM        = V_BOTTOM_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_TOP           = V_TOP_DEF,
  parameter bit SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos
`ifdef VGA_TIMING_STROBES_EN
  ,
  output logic               line_start,
  output logic               frame_start
`endif
);

  localparam int H_MAX = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int V_MAX = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

  // Counters are 10 bits wide; a longer raster would silently alias.
  generate
    if (H_MAX > COORD_LIM || V_MAX > COORD_LIM) begin : g_bad_timing
      $error("vga_timing_gen: H_MAX=%0d / V_MAX=%0d exceed 10-bit coordinate range", H_MAX, V_MAX);
    end
  endgenerate

  logic h_wrap;
  logic v_wrap;
  coord_t h_cnt;
  coord_t v_cnt;

  vga_axis_counter #(
    .MAX             (H_MAX),
    .SYNC_START      (H_DISPLAY + H_FRONT),
    .SYNC_END        (H_DISPLAY + H_FRONT + H_SYNC - 1),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .cnt   (h_cnt),
    .wrap  (h_wrap),
    .sync  (hsync)
  );

  // Lines advance only on the last pixel of a line, so vsync flips at hpos 0.
  vga_axis_counter #(
    .MAX             (V_MAX),
    .SYNC_START      (V_DISPLAY + V_BOTTOM),
    .SYNC_END        (V_DISPLAY + V_BOTTOM + V_SYNC - 1),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap),
    .sync  (vsync)
  );

  assign hpos       = h_cnt;
  assign vpos       = v_cnt;
  assign display_on = (h_cnt < coord_t'(H_DISPLAY)) && (v_cnt < coord_t'(V_DISPLAY));

`ifdef VGA_TIMING_STROBES_EN
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Wrap flags predict hpos/vpos returning to 0 on the coming edge, so the
  // registered strobes land in the same cycle as the (0,*) / (0,0) position.
  always_comb begin
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  // Reset value is 1 because reset parks the beam at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: self-checking bench for vga_timing_gen: a full-size instance for line timing and a
// shrunken, positive-sync instance for vertical/frame timing within a short run.
// Latency/backpressure: n/a (bench).
module tb_vga_timing_gen;

  // Full-size instance constants.
  localparam int D_HD = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VD = 480, D_VB = 10, D_VS = 2,  D_VT = 33;
  localparam int D_HMAX = 799, D_VMAX = 524;

  // Shrunken instance: 24 clocks/line, 19 lines/frame, active-high sync.
  localparam int S_HD = 16, S_HF = 2, S_HS = 4, S_HB = 2;
  localparam int S_VD = 12, S_VB = 2, S_VS = 2, S_VT = 3;
  localparam int S_HMAX = 23, S_VMAX = 18;
  localparam int S_FRAME = 456;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       d_hsync, d_vsync, d_de;
  logic [9:0] d_hpos, d_vpos;
  logic       s_hsync, s_vsync, s_de;
  logic [9:0] s_hpos, s_vpos;
`ifdef VGA_TIMING_STROBES_EN
  logic       d_ls, d_fs, s_ls, s_fs;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int dm_h = 0, dm_v = 0;
  int sm_h = 0, sm_v = 0;
  exp_t dq[$];
  exp_t sq[$];

  always #20 clk = ~clk;

  vga_timing_gen dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (d_hsync),
    .vsync      (d_vsync),
    .display_on (d_de),
    .hpos       (d_hpos),
    .vpos       (d_vpos)
`ifdef VGA_TIMING_STROBES_EN
    ,
    .line_start (d_ls),
    .frame_start(d_fs)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_BOTTOM(S_VB), .V_SYNC(S_VS), .V_TOP(S_VT),
    .SYNC_ACTIVE_LOW(1'b0)
  ) dut_s (
    .clk        (clk),
    .reset      (reset),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .display_on (s_de),
    .hpos       (s_hpos),
    .vpos       (s_vpos)
`ifdef VGA_TIMING_STROBES_EN
    ,
    .line_start (s_ls),
    .frame_start(s_fs)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: outputs as a pure function of beam position and timing.
  function automatic exp_t mk(input int h, input int v, input int hd, input int hf, input int hs,
                              input int vd, input int vb, input int vs, input bit al);
    exp_t e;
    e.h  = h[9:0];
    e.v  = v[9:0];
    e.hs = ((h >= hd + hf) && (h < hd + hf + hs)) ? ~al : al;
    e.vs = ((v >= vd + vb) && (v < vd + vb + vs)) ? ~al : al;
    e.de = (h < hd) && (v < vd);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  // One clock: advance the models on the edge, queue expectations, compare on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (!reset) begin
      if (dm_h == D_HMAX) begin
        dm_h = 0;
        dm_v = (dm_v == D_VMAX) ? 0 : dm_v + 1;
      end else dm_h++;
      if (sm_h == S_HMAX) begin
        sm_h = 0;
        sm_v = (sm_v == S_VMAX) ? 0 : sm_v + 1;
      end else sm_h++;
    end
    dq.push_back(mk(dm_h, dm_v, D_HD, D_HF, D_HS, D_VD, D_VB, D_VS, 1'b1));
    sq.push_back(mk(sm_h, sm_v, S_HD, S_HF, S_HS, S_VD, S_VB, S_VS, 1'b0));
    @(negedge clk);
    cyc++;
    chk("d.sb_depth", dq.size(), 1);
    if (dq.size() > 0) begin
      e = dq.pop_front();
      chk("d.hpos", d_hpos, e.h);
      chk("d.vpos", d_vpos, e.v);
      chk("d.hsync", d_hsync, e.hs);
      chk("d.vsync", d_vsync, e.vs);
      chk("d.display_on", d_de, e.de);
`ifdef VGA_TIMING_STROBES_EN
      chk("d.line_start", d_ls, e.ls);
      chk("d.frame_start", d_fs, e.fs);
`endif
    end
    chk("s.sb_depth", sq.size(), 1);
    if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("s.hpos", s_hpos, e.h);
      chk("s.vpos", s_vpos, e.v);
      chk("s.hsync", s_hsync, e.hs);
      chk("s.vsync", s_vsync, e.vs);
      chk("s.display_on", s_de, e.de);
`ifdef VGA_TIMING_STROBES_EN
      chk("s.line_start", s_ls, e.ls);
      chk("s.frame_start", s_fs, e.fs);
`endif
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".d.hpos"}, d_hpos, 0);
    chk({tag, ".d.vpos"}, d_vpos, 0);
    chk({tag, ".d.hsync"}, d_hsync, 1);
    chk({tag, ".d.vsync"}, d_vsync, 1);
    chk({tag, ".d.display_on"}, d_de, 1);
    chk({tag, ".s.hpos"}, s_hpos, 0);
    chk({tag, ".s.vpos"}, s_vpos, 0);
    chk({tag, ".s.hsync"}, s_hsync, 0);
    chk({tag, ".s.vsync"}, s_vsync, 0);
`ifdef VGA_TIMING_STROBES_EN
    chk({tag, ".d.line_start"}, d_ls, 1);
    chk({tag, ".d.frame_start"}, d_fs, 1);
    chk({tag, ".s.frame_start"}, s_fs, 1);
`endif
  endtask

  initial begin
    logic [9:0] prev_dh = 10'd0;
    logic       prev_dhs = 1'b1;
    logic       prev_svs = 1'b0;
    int last_dhs_fall = -1;
    int last_s_origin = -1;
    int last_svs_rise = -1;
    int s_origins = 0;
    int n;
`ifdef VGA_TIMING_STROBES_EN
    int last_s_ls = -1;
    int last_s_fs = -1;
`endif

    // Reset held across several edges: counters must stay parked.
    repeat (3) tick();
    chk_reset_vals("reset_hold");

    // Release between edges; first edge afterwards moves to hpos 1.
    reset = 1'b0;
    #1;
    chk("release.d.hpos", d_hpos, 0);
    cyc = 0;

    for (int i = 0; i < 2500; i++) begin
      tick();
      if (i == 0) chk("first_edge.d.hpos", d_hpos, 1);
      if (dm_v == 0 && dm_h == 639) chk("de@639", d_de, 1);
      if (dm_v == 0 && dm_h == 640) chk("de@640", d_de, 0);
      if (dm_h == 655) chk("hsync@655", d_hsync, 1);
      if (dm_h == 656) chk("hsync@656", d_hsync, 0);
      if (dm_h == 751) chk("hsync@751", d_hsync, 0);
      if (dm_h == 752) chk("hsync@752", d_hsync, 1);
      if (prev_dh == 10'd799) begin
        chk("wrap.d.hpos", d_hpos, 0);
        if (dm_v == 1) chk("wrap.d.vpos", d_vpos, 1);
      end
      if (prev_dhs && !d_hsync) begin
        if (last_dhs_fall >= 0) chk("hsync_period", cyc - last_dhs_fall, 800);
        last_dhs_fall = cyc;
      end
      if (sm_h == 0 && sm_v >= 13 && sm_v <= 16)
        chk("s.vsync_line", s_vsync, (sm_v == 14 || sm_v == 15) ? 1 : 0);
      if (sm_v >= S_VD) chk("s.de_blank", s_de, 0);
      if (s_hpos == 10'd0 && s_vpos == 10'd0) begin
        if (last_s_origin >= 0) chk("s.frame_period", cyc - last_s_origin, S_FRAME);
        last_s_origin = cyc;
        s_origins++;
      end
      if (!prev_svs && s_vsync) begin
        if (last_svs_rise >= 0) chk("s.vsync_period", cyc - last_svs_rise, S_FRAME);
        last_svs_rise = cyc;
      end
`ifdef VGA_TIMING_STROBES_EN
      if (s_ls) begin
        if (last_s_ls >= 0) chk("s.line_start_period", cyc - last_s_ls, 24);
        last_s_ls = cyc;
      end
      if (s_fs) begin
        if (last_s_fs >= 0) chk("s.frame_start_period", cyc - last_s_fs, S_FRAME);
        last_s_fs = cyc;
      end
`endif
      prev_dh  = d_hpos;
      prev_dhs = d_hsync;
      prev_svs = s_vsync;
    end
    chk("s.frame_origins_seen", s_origins, 5);

    // Walk to a mid-frame position, then hit reset between clock edges.
    n = 0;
    while (!(sm_h == 10 && sm_v == 8) && n < 1000) begin
      tick();
      n++;
    end
    chk("reach_midframe", (n < 1000) ? 1 : 0, 1);
    chk("midframe.s.hpos", s_hpos, 10);
    chk("midframe.s.vpos", s_vpos, 8);
    @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    dm_h = 0; dm_v = 0; sm_h = 0; sm_v = 0;
    tick();
    reset = 1'b0;
    tick();
    chk("restart.d.hpos", d_hpos, 1);
    chk("restart.s.hpos", s_hpos, 1);
    chk("restart.s.vpos", s_vpos, 0);
    repeat (60) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
